// File: rtl/mask_enc_pkg.sv
// mask_enc_pkg: shared definitions for the mask encoder.
//   state_t  : FSM state word
//   ST_IDLE  : waiting for a mask (in_ready high)
//   ST_DRAIN : emitting one beat per set bit of the pending mask
package mask_enc_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_DRAIN = 1'b1;

endpackage : mask_enc_pkg

// File: rtl/mask_encoder_if.sv
// mask_encoder_if: input-mask and output-address handshakes of the mask encoder.
//   in_valid/in_ready/in_mask             : mask offer (producer -> encoder)
//   out_valid/out_ready/out_addr/
//   out_last/out_empty                    : address beats (encoder -> consumer)
// Modports: slave = encoder side, master = producer/consumer side.
interface mask_encoder_if #(
  parameter int f_wid = 6,
  parameter int a_wid = $clog2(f_wid)
);

  logic             in_valid;
  logic             in_ready;
  logic [f_wid-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [a_wid-1:0] out_addr;
  logic             out_last;
  logic             out_empty;

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_addr, out_last, out_empty
  );

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_addr, out_last, out_empty
  );

endinterface : mask_encoder_if

// File: rtl/mask_encoder_lsb_index.sv
// lsb_index: combinational lowest-set-bit finder.
//   vec      : input bit vector
//   index    : position of the lowest set bit (0 when vec is zero)
//   one_left : vec has at most one bit set
module lsb_index #(
  parameter int f_wid = 6,
  parameter int a_wid = $clog2(f_wid)
) (
  input  logic [f_wid-1:0] vec,
  output logic [a_wid-1:0] index,
  output logic             one_left
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = f_wid - 1; i >= 0; i--) begin
      if (vec[i]) index = a_wid'(i);
    end
  end

  // Clearing the lowest set bit leaves zero iff at most one bit was set.
  assign one_left = ~|(vec & (vec - f_wid'(1)));

endmodule : lsb_index

// File: rtl/mask_encoder.sv
// mask_encoder: captures a bit mask and emits the index of each set bit,
// lowest first, one beat per cycle under valid/ready flow control.
// An all-zero mask yields a single beat flagged empty.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mask_encoder_if.slave (in_* mask handshake, out_* address beats)
// All outputs come from state/pend/empty registers only.
module mask_encoder
  import mask_enc_pkg::*;
#(
  parameter int f_wid = 6,
  parameter int a_wid = $clog2(f_wid)
) (
  input  logic           clk,
  input  logic           rst_n,
  mask_encoder_if.slave  bus
);

  state_t           state;
  logic [f_wid-1:0] pend;
  logic             empty_r;
  logic [a_wid-1:0] lsb;
  logic             one_left;
  logic             drain;

  lsb_index #(.f_wid(f_wid), .a_wid(a_wid)) u_lsb (
    .vec      (pend),
    .index    (lsb),
    .one_left (one_left)
  );

  assign drain = (state == ST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pend    <= '0;
      empty_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            pend    <= bus.in_mask;
            empty_r <= ~|bus.in_mask;
            state   <= ST_DRAIN;
          end
        end
        default: begin
          if (bus.out_ready) begin
            // Drop the emitted (lowest) bit; a zero mask stays zero.
            pend <= pend & (pend - f_wid'(1));
            if (one_left) begin
              state   <= ST_IDLE;
              empty_r <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = ~drain;
  assign bus.out_valid = drain;
  // pend is zero outside DRAIN, so lsb is already 0 there.
  assign bus.out_addr  = lsb;
  assign bus.out_last  = drain & one_left;
  assign bus.out_empty = drain & empty_r;

endmodule : mask_encoder

// File: doc/mask_encoder.md
MASK_ENCODER -- requirements
Module: mask_encoder

Interface
REQ-001 SHALL have parameter f_wid, default 6: width of the input bit mask (legal range 2..64).
REQ-002 SHALL have parameter a_wid, default $clog2(f_wid): width of the emitted address.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: in_mask is offered.
REQ-006 SHALL have port in_ready, output, 1: block accepts a mask this cycle.
REQ-007 SHALL have port in_mask, input, f_wid: bit i set means address i is requested.
REQ-008 SHALL have port out_valid, output, 1: out_addr/out_last/out_empty are valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the current beat.
REQ-010 SHALL have port out_addr, output, a_wid: index of the emitted set bit.
REQ-011 SHALL have port out_last, output, 1: final beat for the current mask.
REQ-012 SHALL have port out_empty, output, 1: the captured mask was all-zero.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and DRAIN.
REQ-014 SHALL drive in_ready = 1 in IDLE and 0 in DRAIN.
REQ-015 SHALL, on in_valid & in_ready, register in_mask into the pending register pend and enter DRAIN on the next edge.
REQ-016 SHALL ignore in_mask and in_valid while in_ready = 0.
REQ-017 SHALL assert out_valid throughout DRAIN, first in the cycle after capture (latency 1).
REQ-018 SHALL drive out_addr as the index of the lowest set bit of pend.
REQ-019 SHALL drive out_last = 1 when pend has at most one bit set.
REQ-020 SHALL, for an all-zero captured mask, emit exactly one beat with out_addr = 0, out_empty = 1 and out_last = 1.
REQ-021 SHALL drive out_empty = 0 for any non-zero captured mask.
REQ-022 SHALL, on out_valid & out_ready, clear the emitted bit of pend.
REQ-023 SHALL, when the accepted beat has out_last = 1, return to IDLE on that edge.
REQ-024 SHALL hold out_addr, out_last and out_empty stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL sustain one beat per cycle with out_ready held high: a mask with k set bits occupies k+1 cycles from capture to next in_ready.
REQ-026 SHALL derive every output from registers only, with no combinational path from in_* or out_ready to any output.
REQ-027 SHALL emit addresses in strictly ascending order, each set bit exactly once.

Reset
REQ-028 SHALL, while rst_n = 0, immediately force state IDLE, pend = 0, out_valid = 0, out_addr = 0, out_last = 0, out_empty = 0 and in_ready = 1.
REQ-029 SHALL discard any partially drained mask on reset, emitting no further beats for it.

Structure
REQ-030 SHALL take the FSM state enumeration from a shared package mask_enc_pkg.
REQ-031 SHALL place the lowest-set-bit index function in a sub-module lsb_index (parameters f_wid, a_wid; outputs index and a one_left flag).

Verification
REQ-032 SHALL cover: in_mask = 6'b000100, out_ready = 1 -> a single beat with addr 2, last = 1, empty = 0; in_ready high again one cycle later.
REQ-033 SHALL cover: 6'b101001, out_ready = 1 -> addrs 0, 3, 5 on consecutive cycles, last only on 5, in_ready low for 3 cycles.
REQ-034 SHALL cover: 6'b000000 -> one beat with addr 0, empty = 1, last = 1.
REQ-035 SHALL cover: 6'b100010 with out_ready low for 3 cycles -> addr 1 held stable, then 1 and 5 delivered once out_ready rises.
REQ-036 SHALL cover: 6'b111111 with reset asserted after 2 beats -> out_valid drops asynchronously; after release, mask 6'b010000 -> a single beat with addr 4, last = 1.
REQ-037 SHALL cover: back-to-back in_valid with masks 6'b000011 then 6'b100000 -> 0, 1, 5 emitted; the second mask is captured only in the cycle in_ready = 1.
